// File: rtl/video_timing_gen_pkg.sv
// Shared video definitions: the VideoMode timing record, standard modes and
// helpers that derive the line/field totals from a record.
package video_timing_gen_pkg;

  localparam int unsigned VM_W = 12;

  typedef struct packed {
    logic [VM_W-1:0] h_sync, h_back_porch, h_active, h_front_porch;
    logic [VM_W-1:0] v_sync, v_back_porch_1, v_back_porch_2, v_active, v_front_porch;
    logic            interlaced, h_sync_pol, v_sync_pol;
  } VideoMode;

  localparam VideoMode MODE_640X480P60 = '{
    h_sync: 12'd96, h_back_porch: 12'd48, h_active: 12'd640, h_front_porch: 12'd16,
    v_sync: 12'd2, v_back_porch_1: 12'd33, v_back_porch_2: 12'd33, v_active: 12'd480,
    v_front_porch: 12'd10, interlaced: 1'b0, h_sync_pol: 1'b0, v_sync_pol: 1'b0};

  localparam VideoMode MODE_1280X720P60 = '{
    h_sync: 12'd40, h_back_porch: 12'd220, h_active: 12'd1280, h_front_porch: 12'd110,
    v_sync: 12'd5, v_back_porch_1: 12'd20, v_back_porch_2: 12'd20, v_active: 12'd720,
    v_front_porch: 12'd5, interlaced: 1'b0, h_sync_pol: 1'b1, v_sync_pol: 1'b1};

  // Field 2 carries the extra half-line of back porch as a whole line.
  localparam VideoMode MODE_1920X1080I60 = '{
    h_sync: 12'd44, h_back_porch: 12'd148, h_active: 12'd1920, h_front_porch: 12'd88,
    v_sync: 12'd5, v_back_porch_1: 12'd15, v_back_porch_2: 12'd16, v_active: 12'd540,
    v_front_porch: 12'd2, interlaced: 1'b1, h_sync_pol: 1'b1, v_sync_pol: 1'b1};

  function automatic logic [VM_W-1:0] mode_h_total(VideoMode m);
    return m.h_sync + m.h_back_porch + m.h_active + m.h_front_porch;
  endfunction

  function automatic logic [VM_W-1:0] mode_v_total(VideoMode m, logic field);
    return m.v_sync + (field ? m.v_back_porch_2 : m.v_back_porch_1) + m.v_active +
           m.v_front_porch;
  endfunction

  function automatic logic mode_ok(VideoMode m);
    return (mode_h_total(m) != '0) && (mode_v_total(m, 1'b0) != '0) &&
           (mode_v_total(m, 1'b1) != '0);
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter plus next-cycle sync/window decode
// and a registered visible index.
module video_axis_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] total,
  input  logic [CNT_W-1:0] sync_len,
  input  logic [CNT_W-1:0] start,
  input  logic [CNT_W-1:0] active_len,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_hit,
  output logic             in_win,
  output logic [CNT_W-1:0] vis
);

  logic [CNT_W-1:0] count_d, vis_d;

  assign wrap = en && (count == total - 1'b1);

  always_comb begin
    count_d = count;
    if (clear || wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count + 1'b1;
    end
  end

  // Decode is taken from the next count so it lands in the same cycle as the count.
  assign sync_hit = count_d < sync_len;
  assign in_win   = (count_d >= start) && (count_d - start < active_len);
  assign vis_d    = in_win ? count_d - start : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      vis   <= '0;
    end else begin
      count <= count_d;
      vis   <= vis_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, field flag and sync/DE strobes from a shadowed
// VideoMode that is only replaced at a frame boundary.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  VideoMode         videoMode,
  input  logic             mode_update,
  output logic [CNT_W-1:0] counterX,
  output logic [CNT_W-1:0] counterY,
  output logic [CNT_W-1:0] visible_counterX,
  output logic [CNT_W-1:0] visible_counterY,
  output logic             state,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             mode_busy
);

  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic     fsm_q;
  VideoMode mode_q, mode_d;
  logic     valid_q, valid_d, pending_q, pending_d, state_q, state_d;
  logic     run, cand_ok, frame_end, reload, take, clear;
  logic     h_wrap, h_sync_hit, h_in_win, v_wrap, v_sync_hit, v_in_win;
  logic [VM_W-1:0] v_bp_d;

  assign run       = (fsm_q == ST_RUN);
  assign cand_ok   = mode_ok(videoMode);
  assign frame_end = v_wrap & (~mode_q.interlaced | state_q);
  // With no valid shadow there is no frame to finish, so a request is taken at once.
  assign reload    = run & pending_q & (frame_end | ~valid_q);
  assign take      = ~run | reload;
  assign mode_d    = (take && cand_ok) ? videoMode : mode_q;
  assign valid_d   = valid_q | (take & cand_ok);
  assign clear     = take | ~valid_d;
  assign pending_d = mode_update | (pending_q & ~reload);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = 1'b0;
    end else if (v_wrap) begin
      state_d = mode_q.interlaced & ~state_q;
    end
  end

  assign v_bp_d = state_d ? mode_d.v_back_porch_2 : mode_d.v_back_porch_1;

  video_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
    .clock      (clock),
    .resetn     (resetn),
    .en         (run & valid_q),
    .clear      (clear),
    .total      (CNT_W'(mode_h_total(mode_q))),
    .sync_len   (CNT_W'(mode_d.h_sync)),
    .start      (CNT_W'(mode_d.h_sync + mode_d.h_back_porch)),
    .active_len (CNT_W'(mode_d.h_active)),
    .count      (counterX),
    .wrap       (h_wrap),
    .sync_hit   (h_sync_hit),
    .in_win     (h_in_win),
    .vis        (visible_counterX)
  );

  video_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
    .clock      (clock),
    .resetn     (resetn),
    .en         (h_wrap),
    .clear      (clear),
    .total      (CNT_W'(mode_v_total(mode_q, state_q))),
    .sync_len   (CNT_W'(mode_d.v_sync)),
    .start      (CNT_W'(mode_d.v_sync + v_bp_d)),
    .active_len (CNT_W'(mode_d.v_active)),
    .count      (counterY),
    .wrap       (v_wrap),
    .sync_hit   (v_sync_hit),
    .in_win     (v_in_win),
    .vis        (visible_counterY)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm_q       <= ST_LOAD;
      mode_q      <= '0;
      valid_q     <= 1'b0;
      pending_q   <= 1'b0;
      state_q     <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      fsm_q       <= ST_RUN;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      hsync       <= valid_d & (h_sync_hit ^ ~mode_d.h_sync_pol);
      vsync       <= valid_d & (v_sync_hit ^ ~mode_d.v_sync_pol);
      de          <= valid_d & h_in_win & v_in_win;
      // Counters land on (0,0) exactly after a clear or a field/frame wrap.
      frame_start <= valid_d & (take | v_wrap);
    end
  end

  assign state     = state_q;
  assign mode_busy = pending_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against a raster-position model plus
// hand-computed checkpoints for 640x480, interlace and mode-update timing.
module tb_video_timing_gen;
  import video_timing_gen_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  VideoMode   vm;
  logic       mode_update = 1'b0;
  logic [11:0] counterX, counterY, visible_counterX, visible_counterY;
  logic       state, hsync, vsync, de, frame_start, mode_busy;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clock = ~clock;

  video_timing_gen #(.CNT_W(12)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .videoMode        (vm),
    .mode_update      (mode_update),
    .counterX         (counterX),
    .counterY         (counterY),
    .visible_counterX (visible_counterX),
    .visible_counterY (visible_counterY),
    .state            (state),
    .hsync            (hsync),
    .vsync            (vsync),
    .de               (de),
    .frame_start      (frame_start),
    .mode_busy        (mode_busy)
  );

  // Model: where the beam is, which field, which mode, and whether a change waits.
  typedef struct {
    bit       run, valid, pend, f;
    VideoMode mode;
    int       x, y;
  } mstate_t;

  typedef struct packed {
    logic [11:0] cx, cy, vx, vy;
    logic        st, hs, vs, de, fs, busy;
  } out_t;

  mstate_t ms;

  function automatic int htot(VideoMode m);
    return int'(m.h_sync) + int'(m.h_back_porch) + int'(m.h_active) + int'(m.h_front_porch);
  endfunction

  function automatic int vtot(VideoMode m, bit f);
    return int'(m.v_sync) + (f ? int'(m.v_back_porch_2) : int'(m.v_back_porch_1)) +
           int'(m.v_active) + int'(m.v_front_porch);
  endfunction

  function automatic bit good(VideoMode m);
    return htot(m) != 0 && vtot(m, 1'b0) != 0 && vtot(m, 1'b1) != 0;
  endfunction

  function automatic bit at_eof(mstate_t s);
    return s.run && s.valid && s.x == htot(s.mode) - 1 && s.y == vtot(s.mode, s.f) - 1 &&
           (!s.mode.interlaced || s.f);
  endfunction

  function automatic mstate_t reset_state();
    mstate_t s;
    s.run = 0; s.valid = 0; s.pend = 0; s.f = 0; s.mode = '0; s.x = 0; s.y = 0;
    return s;
  endfunction

  function automatic mstate_t step(mstate_t s, VideoMode in_mode, bit upd);
    mstate_t n;
    bit rel;
    n = s;
    if (!s.run) begin
      n.run = 1;
      if (good(in_mode)) begin n.mode = in_mode; n.valid = 1; end
      n.pend = upd;
      return n;
    end
    rel = s.pend && (at_eof(s) || !s.valid);
    if (s.valid) begin
      n.x = s.x + 1;
      if (n.x == htot(s.mode)) begin
        n.x = 0;
        n.y = s.y + 1;
        if (n.y == vtot(s.mode, s.f)) begin
          n.y = 0;
          n.f = s.mode.interlaced ? !s.f : 1'b0;
        end
      end
    end
    if (rel) begin
      if (good(in_mode)) begin n.mode = in_mode; n.valid = 1; end
      n.x = 0; n.y = 0; n.f = 0;
    end
    n.pend = upd || (s.pend && !rel);
    return n;
  endfunction

  function automatic out_t expect_out(mstate_t s);
    out_t o;
    int hst, vst, hact, vact;
    bit inh, inv, hraw, vraw;
    o = '0;
    o.busy = s.pend;
    if (!(s.run && s.valid)) return o;
    hst  = int'(s.mode.h_sync) + int'(s.mode.h_back_porch);
    vst  = int'(s.mode.v_sync) + (s.f ? int'(s.mode.v_back_porch_2)
                                      : int'(s.mode.v_back_porch_1));
    hact = int'(s.mode.h_active);
    vact = int'(s.mode.v_active);
    inh  = s.x >= hst && s.x < hst + hact;
    inv  = s.y >= vst && s.y < vst + vact;
    hraw = s.x < int'(s.mode.h_sync);
    vraw = s.y < int'(s.mode.v_sync);
    o.cx = 12'(s.x);
    o.cy = 12'(s.y);
    o.vx = inh ? 12'(s.x - hst) : 12'd0;
    o.vy = inv ? 12'(s.y - vst) : 12'd0;
    o.st = s.f;
    o.hs = s.mode.h_sync_pol ? hraw : !hraw;
    o.vs = s.mode.v_sync_pol ? vraw : !vraw;
    o.de = inh && inv;
    o.fs = s.x == 0 && s.y == 0;
    return o;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) ms <= reset_state();
    else         ms <= step(ms, vm, mode_update);
  end

  always @(negedge clock) begin
    out_t a, e;
    a = {counterX, counterY, visible_counterX, visible_counterY,
         state, hsync, vsync, de, frame_start, mode_busy};
    e = expect_out(ms);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL outputs @%0t: got cx=%0d cy=%0d vx=%0d vy=%0d st=%b hs=%b vs=%b de=%b fs=%b busy=%b, want cx=%0d cy=%0d vx=%0d vy=%0d st=%b hs=%b vs=%b de=%b fs=%b busy=%b",
               $time, a.cx, a.cy, a.vx, a.vy, a.st, a.hs, a.vs, a.de, a.fs, a.busy,
               e.cx, e.cy, e.vx, e.vy, e.st, e.hs, e.vs, e.de, e.fs, e.busy);
    end
  end

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic pulse();
    mode_update = 1'b1;
    @(negedge clock);
    mode_update = 1'b0;
  endtask

  task automatic wait_idle(int bound, string nm);
    int k = 0;
    while (mode_busy && k < bound) begin @(negedge clock); k++; end
    chk(nm, int'(mode_busy), 0);
  endtask

  task automatic wait_eof(int bound);
    int k = 0;
    while (!at_eof(ms) && k < bound) begin @(negedge clock); k++; end
    chk("reach frame end", int'(at_eof(ms)), 1);
  endtask

  task automatic async_reset_check();
    #2 resetn = 1'b0;
    #1;
    chk("async reset counterX", int'(counterX), 0);
    chk("async reset counterY", int'(counterY), 0);
    chk("async reset de", int'(de), 0);
    chk("async reset hsync", int'(hsync), 0);
    @(negedge clock);
  endtask

  function automatic VideoMode small_mode(bit il);
    VideoMode m;
    m.h_sync = 12'($urandom_range(1, 4));         m.h_back_porch = 12'($urandom_range(0, 4));
    m.h_active = 12'($urandom_range(1, 8));       m.h_front_porch = 12'($urandom_range(0, 3));
    m.v_sync = 12'($urandom_range(1, 3));         m.v_back_porch_1 = 12'($urandom_range(0, 3));
    m.v_back_porch_2 = 12'($urandom_range(0, 3)); m.v_active = 12'($urandom_range(1, 5));
    m.v_front_porch = 12'($urandom_range(0, 2));  m.interlaced = il;
    m.h_sync_pol = 1'($urandom_range(0, 1));      m.v_sync_pol = 1'($urandom_range(0, 1));
    return m;
  endfunction

  VideoMode mode_a, mode_b, mode_i;

  initial begin
    // 8x7 progressive, 12x8 progressive, 8 x (7|8) interlaced
    mode_a = '{h_sync: 2, h_back_porch: 1, h_active: 4, h_front_porch: 1, v_sync: 2,
               v_back_porch_1: 1, v_back_porch_2: 1, v_active: 3, v_front_porch: 1,
               interlaced: 0, h_sync_pol: 1, v_sync_pol: 0};
    mode_b = '{h_sync: 3, h_back_porch: 2, h_active: 5, h_front_porch: 2, v_sync: 1,
               v_back_porch_1: 2, v_back_porch_2: 2, v_active: 4, v_front_porch: 1,
               interlaced: 0, h_sync_pol: 0, v_sync_pol: 1};
    mode_i = '{h_sync: 2, h_back_porch: 1, h_active: 4, h_front_porch: 1, v_sync: 2,
               v_back_porch_1: 1, v_back_porch_2: 2, v_active: 3, v_front_porch: 1,
               interlaced: 1, h_sync_pol: 1, v_sync_pol: 1};

    vm = MODE_640X480P60;
    repeat (3) @(negedge clock);
    chk("reset counterX", int'(counterX), 0);
    chk("reset hsync", int'(hsync), 0);
    chk("reset de", int'(de), 0);
    chk("reset mode_busy", int'(mode_busy), 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("after load counterX", int'(counterX), 0);
    chk("after load counterY", int'(counterY), 0);
    chk("after load frame_start", int'(frame_start), 1);
    chk("after load hsync (active low)", int'(hsync), 0);

    begin
      int hs_low = 0, first_de = -1, fx = 0, fy = 0, fvx = -1, de_line = 0;
      int last_vx = 0, max_cx = 0;
      for (int i = 0; i <= 28800; i++) begin
        if (i > 0) @(negedge clock);
        if (i < 800 && !hsync) hs_low++;
        if (int'(counterX) > max_cx) max_cx = int'(counterX);
        if (de && first_de < 0) begin
          first_de = i; fx = int'(counterX); fy = int'(counterY); fvx = int'(visible_counterX);
        end
        if (counterY == 12'd35 && de) begin de_line++; last_vx = int'(visible_counterX); end
      end
      chk("hsync low cycles per line", hs_low, 96);
      chk("max counterX", max_cx, 799);
      chk("first de cycle", first_de, 28144);
      chk("first de counterX", fx, 144);
      chk("first de counterY", fy, 35);
      chk("first de visible_counterX", fvx, 0);
      chk("de cycles in line 35", de_line, 640);
      chk("last visible_counterX", last_vx, 639);
    end

    repeat (300) @(negedge clock);
    chk("pre-reset counterX", int'(counterX), 300);
    async_reset_check();
    vm = '0;
    resetn = 1'b1;
    repeat (30) @(negedge clock);
    chk("degenerate counterX held", int'(counterX), 0);
    chk("degenerate de low", int'(de), 0);
    vm = mode_a;
    pulse();
    wait_idle(20, "recover from degenerate");

    vm = mode_i;
    pulse();
    wait_idle(200, "switch to interlaced");
    begin
      int row[2] = '{-1, -1};
      int rises = 0;
      logic prev = 1'b0;
      for (int i = 0; i < 240; i++) begin
        if (i > 0) @(negedge clock);
        if (state && !prev) rises++;
        prev = state;
        if (de && row[state] < 0) row[state] = int'(counterY);
      end
      chk("field1 first active line", row[0], 3);
      chk("field2 first active line", row[1], 4);
      chk("state rises in two frames", rises, 2);
    end

    vm = mode_a;
    pulse();
    wait_idle(300, "switch back to progressive");
    vm = mode_b;
    wait_eof(200);
    pulse();
    chk("update on frame end: counterX", int'(counterX), 0);
    chk("update on frame end: busy kept", int'(mode_busy), 1);
    begin
      int k = 0;
      while (mode_busy && k < 500) begin @(negedge clock); k++; end
      chk("update on frame end: delay", k, 56);
    end

    vm = mode_a;
    repeat (5) @(negedge clock);
    pulse();
    repeat (20) @(negedge clock);
    pulse();
    begin
      int falls = 0;
      logic prev = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clock);
        if (prev && !mode_busy) falls++;
        prev = mode_busy;
      end
      chk("merged pulses switch count", falls, 1);
    end

    for (int r = 0; r < 60; r++) begin
      vm = ($urandom_range(0, 7) == 0) ? VideoMode'('0) : small_mode(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        async_reset_check();
        resetn = 1'b1;
      end else begin
        pulse();
        repeat ($urandom_range(0, 20)) @(negedge clock);
        vm = small_mode(1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) pulse();
      end
      repeat ($urandom_range(20, 400)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
